// File: rtl/bcd_to_hex.sv
// Sequential BCD-to-binary converter: one digit per clock, most significant first,
// with start/busy/done handshake and overflow / invalid-digit flags.
module bcd_to_hex #(
  parameter int unsigned NDIG  = 10,
  parameter int unsigned OUT_W = 31
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*NDIG-1:0]   bcd_in,
  output logic                busy,
  output logic                done,
  output logic [OUT_W-1:0]    hex_out,
  output logic                overflow,
  output logic                invalid
);

  localparam int unsigned CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [4*NDIG-1:0]   sreg;
  logic [OUT_W-1:0]    acc;
  logic [CW-1:0]       cnt;
  logic                ovf_s, inv_s;

  logic [3:0]          d;
  logic [OUT_W+3:0]    p;
  logic                p_ovf, d_inv, last, accept;

  always_comb begin
    d      = sreg[4*NDIG-1 -: 4];
    p      = (OUT_W+4)'(acc) * (OUT_W+4)'(10) + (OUT_W+4)'(d);
    p_ovf  = |p[OUT_W+3:OUT_W];
    d_inv  = (d > 4'd9);
    last   = (cnt == CW'(NDIG-1));
    accept = start && (state != CONV);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CONV;
      CONV:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? CONV : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with state itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CONV);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg     <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_s    <= 1'b0;
      inv_s    <= 1'b0;
      hex_out  <= '0;
      overflow <= 1'b0;
      invalid  <= 1'b0;
    end else if (accept) begin
      sreg  <= bcd_in;
      acc   <= '0;
      cnt   <= '0;
      ovf_s <= 1'b0;
      inv_s <= 1'b0;
    end else if (state == CONV) begin
      acc   <= p[OUT_W-1:0];
      ovf_s <= ovf_s | p_ovf;
      inv_s <= inv_s | d_inv;
      sreg  <= sreg << 4;
      cnt   <= cnt + CW'(1);
      if (last) begin
        hex_out  <= p[OUT_W-1:0];
        overflow <= ovf_s | p_ovf;
        invalid  <= inv_s | d_inv;
      end
    end
  end

endmodule

// File: tb/tb_bcd_to_hex.sv
// Randomized self-checking bench for bcd_to_hex against a positional-arithmetic model.
module tb_bcd_to_hex;

  localparam int unsigned NDIG  = 10;
  localparam int unsigned OUT_W = 31;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                start = 1'b0;
  logic [4*NDIG-1:0]   bcd_in = '0;
  logic                busy, done, overflow, invalid;
  logic [OUT_W-1:0]    hex_out;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bcd_to_hex #(.NDIG(NDIG), .OUT_W(OUT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .bcd_in   (bcd_in),
    .busy     (busy),
    .done     (done),
    .hex_out  (hex_out),
    .overflow (overflow),
    .invalid  (invalid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // True value of the digit string, then reduced to the output width.
  task automatic model(input logic [4*NDIG-1:0] v, output logic [OUT_W-1:0] h,
                       output logic o, output logic i);
    longint unsigned t, w;
    logic [3:0] dg;
    t = 0; w = 1; i = 1'b0;
    for (int k = 0; k < int'(NDIG); k++) begin
      dg = v[4*k +: 4];
      t  = t + longint'(dg) * w;
      w  = w * 10;
      if (dg > 4'd9) i = 1'b1;
    end
    h = t[OUT_W-1:0];
    o = (t >= (64'd1 << OUT_W));
  endtask

  function automatic logic [4*NDIG-1:0] rand_bcd();
    logic [4*NDIG-1:0] v;
    for (int k = 0; k < int'(NDIG); k++)
      v[4*k +: 4] = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(10, 15))
                                                 : 4'($urandom_range(0, 9));
    return v;
  endfunction

  task automatic check_result(input string tag, input logic [4*NDIG-1:0] v);
    logic [OUT_W-1:0] h;
    logic o, i;
    model(v, h, o, i);
    check({tag, "_hex"}, 64'(hex_out), 64'(h));
    check({tag, "_ovf"}, 64'(overflow), 64'(o));
    check({tag, "_inv"}, 64'(invalid), 64'(i));
  endtask

  // One conversion with a one-cycle start; optionally pokes start/bcd_in mid-conversion.
  task automatic run_conv(input string tag, input logic [4*NDIG-1:0] v, input bit poke);
    int unsigned bc;
    bit seen;
    @(negedge clk);
    bcd_in = v;
    start  = 1'b1;
    bc = 0; seen = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (poke && k == 3) begin start = 1'b1; bcd_in = rand_bcd(); end
      if (poke && k == 4) start = 1'b0;
      if (done) begin seen = 1; break; end
      if (busy) bc++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_busy_cycles"}, 64'(bc), 64'(NDIG));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    check_result(tag, v);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check_result({tag, "_held"}, v);
  endtask

  initial begin
    logic [4*NDIG-1:0] bv [4];
    int unsigned gap, bad;
    bit seen;

    // Reset and idle
    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hex",  64'(hex_out), 64'd0);
    check("rst_flags", 64'({overflow, invalid}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (busy || done || hex_out != '0) bad++;
    end
    check("idle_quiet", 64'(bad), 64'd0);

    // Directed cases
    run_conv("basic",    40'h0000012345, 1'b0);
    check("basic_const", 64'(hex_out), 64'h3039);
    run_conv("max31",    40'h2147483647, 1'b0);
    run_conv("ovf31",    40'h2147483648, 1'b0);
    check("ovf31_const", 64'({hex_out, overflow}), 64'({31'd0, 1'b1}));
    run_conv("all9",     40'h9999999999, 1'b0);
    check("all9_const", 64'(hex_out), 64'd1410065407);
    run_conv("inv1a",    40'h000000001A, 1'b0);
    check("inv1a_const", 64'({hex_out, invalid, overflow}), 64'({31'd20, 1'b1, 1'b0}));
    run_conv("clear7",   40'h0000000007, 1'b0);
    run_conv("poke",     40'h0000987654, 1'b1);

    // Random
    for (int n = 0; n < 24; n++) run_conv("rand", rand_bcd(), n[0]);

    // Back-to-back with start held
    foreach (bv[j]) bv[j] = rand_bcd();
    @(negedge clk);
    bcd_in = bv[0];
    start  = 1'b1;
    for (int j = 0; j < 4; j++) begin
      gap = 0; seen = 0;
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        gap++;
        if (done) begin seen = 1; break; end
      end
      check("b2b_done_seen", 64'(seen), 64'd1);
      check("b2b_gap", 64'(gap), 64'(NDIG + 1));
      check_result("b2b", bv[j]);
      if (j < 3) bcd_in = bv[j+1];
      else start = 1'b0;
    end
    @(negedge clk);
    check("b2b_end_idle", 64'({busy, done}), 64'd0);

    // Reset mid-conversion
    @(negedge clk);
    bcd_in = 40'h0000004321;
    start  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_outs", 64'({hex_out, overflow, invalid, done}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (busy || done) bad++;
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    run_conv("after_rst", 40'h0000004321, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bcd_to_hex.md
# bcd_to_hex

Sequential BCD-to-binary converter: the reverse of the score path's binary-to-BCD stage. It takes a 10-digit packed BCD word, such as an entered or stored high-score value, and produces the 31-bit binary value for comparison and arithmetic logic. Conversion is iterative multiply-by-10-and-add, one digit per clock, most significant digit first. A start/busy/done handshake controls each conversion, and the block flags digits above 9 and results that exceed 31 bits.

## Interface
- NDIG, 10, number of BCD digits in `bcd_in`; the input width is 4*NDIG.
- OUT_W, 31, binary result width.

- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion; sampled only in IDLE or DONE.
- bcd_in  in  4*NDIG  packed BCD; digit 0 is in [3:0], digit NDIG-1 is in [4*NDIG-1:4*NDIG-4]. Sampled on the edge that accepts `start`.
- busy  out  1  high while digits are being processed (state CONV).
- done  out  1  one-cycle pulse; `hex_out` and the flags are valid and updated.
- hex_out  out  OUT_W  converted value, held until the next completion.
- overflow  out  1  the true value is at least 2^OUT_W; held with `hex_out`.
- invalid  out  1  at least one digit was greater than 9; held with `hex_out`.

## Operation
- States: IDLE, CONV, DONE.
- IDLE:
  - On `start`=1, latch `bcd_in` into the digit shift register `sreg`.
  - Clear the accumulator `acc`, the digit counter `cnt`, and the internal sticky flags `ovf_s` and `inv_s`.
  - Go to CONV.
- CONV: each cycle, take `d = sreg[4*NDIG-1 -: 4]` and do all of the following:
  - Compute `p = acc*10 + d` at width OUT_W+4, unsigned.
  - Write `acc <= p[OUT_W-1:0]`, i.e. modulo 2^OUT_W.
  - Set `ovf_s` if `p[OUT_W+3:OUT_W]` is nonzero.
  - Set `inv_s` if `d > 9`. The digit value is still used unchanged in the sum.
  - Shift `sreg` left by 4 and increment `cnt`.
- Last digit: when `cnt == NDIG-1`, the same edge does all of the following:
  - Writes `hex_out` with the final acc value.
  - Writes `overflow` with `ovf_s` OR this cycle's overflow.
  - Writes `invalid` with `inv_s` OR this cycle's invalid check.
  - Moves to DONE.
- DONE:
  - `done`=1 for exactly one cycle.
  - If `start`=1, accept a new conversion, exactly as from IDLE, and go to CONV.
  - Otherwise go to IDLE.
- `start` is ignored in CONV. `bcd_in` changes after acceptance have no effect.
- Because `acc` wraps modulo 2^OUT_W, `hex_out` always equals the true value mod 2^OUT_W. `overflow` is sticky within one conversion, so it is set even when the truncated accumulator no longer shows the excess.
- `busy` and `done` are registered outputs derived from state. They are never high together.

## Timing
- Reset values, applied asynchronously while `rst_n`=0:
  - state IDLE.
  - `busy`=0 and `done`=0.
  - `hex_out`=0, `overflow`=0, `invalid`=0.
  - `sreg`, `acc`, `cnt` and the sticky flags all 0.
- Reset mid-conversion aborts the conversion: no `done` pulse, and all outputs go to their reset values.
- Let E0 be the edge that accepts `start`.
  - `busy` is high from after E0 until after E(NDIG).
  - Digits are processed on E1 through E(NDIG).
  - `hex_out`, `overflow` and `invalid` update at E(NDIG).
  - `done` is high for the cycle between E(NDIG) and E(NDIG+1).
- Latency from the accepting edge to `done` high is NDIG cycles (10 by default).
- Back-to-back conversions: with `start` held high, a new conversion is accepted on the DONE-cycle edge. Throughput is one result per NDIG+1 cycles.
- Outputs hold their last completed values through IDLE and through the next conversion, until the next completion edge.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-run, then release and hold `start`=0.
  - Response: all outputs 0, `busy` never rises, `done` never pulses.
- Basic conversion:
  - Stimulus: `bcd_in`=0x0000012345, one-cycle `start`.
  - Response: `busy` high for exactly 10 cycles, then `done` for 1 cycle, `hex_out`=12345 (0x3039), `overflow`=0, `invalid`=0.
- Range boundary:
  - Stimulus: 0x2147483647.
  - Response: `hex_out`=0x7FFFFFFF, `overflow`=0.
  - Stimulus: 0x2147483648.
  - Response: `hex_out`=0, `overflow`=1.
  - Stimulus: 0x9999999999.
  - Response: `hex_out`=1410065407, `overflow`=1.
- Invalid digit:
  - Stimulus: 0x000000001A.
  - Response: `hex_out`=20, `invalid`=1, `overflow`=0.
  - Follow-up: convert 0x0000000007.
  - Response: `hex_out`=7, both flags cleared.
- Handshake:
  - Stimulus: pulse `start` again during CONV while changing `bcd_in`.
  - Response: the pulse is ignored and the result reflects the original input.
  - Stimulus: hold `start` high continuously with a new `bcd_in` in the DONE cycle.
  - Response: the next conversion starts at the DONE-cycle edge and results arrive every 11 cycles.
- Reset mid-operation:
  - Stimulus: `rst_n` low at cycle 5 of a conversion.
  - Response: outputs are 0 immediately, no `done` pulse, and the next `start` converts normally.
